// File: rtl/multi_pulse_stretch.sv
// multi_pulse_stretch
// Bank of independent pulse stretchers. Each channel turns a trigger on
// in_pulse[i] into a registered pulse of max(stretch_len,1) cycles, with an
// optional fixed hold-off gap after every pulse. Three trigger modes are
// supported:
//   ONESHOT - a trigger while a pulse is running is rejected
//   RETRIG  - a trigger while a pulse is running restarts its length
//   EDGE    - like ONESHOT, but only a rising edge of in_pulse counts
// A trigger that a channel has to reject sets its sticky missed flag.
module multi_pulse_stretch #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int HOLDOFF  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_pulse,
    input  logic [CNT_W-1:0]    stretch_len,
    input  logic [1:0]          mode,
    input  logic                enable,
    input  logic                clr_missed,
    output logic [CHANNELS-1:0] out_pulse,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] missed
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_RETRIG = 2'b01;
    localparam logic [1:0]       MODE_EDGE   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLDOFF);

    // Controls shared by every channel; they are only consumed on the edge
    // that accepts a trigger, so a change mid-pulse affects later triggers only.
    logic [CNT_W-1:0] len_eff;
    logic             is_retrig;
    logic             is_edge;

    // A zero length is stretched to one cycle so the counter never starts at 0.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here by
        // defaulting first), otherwise synthesis infers a latch.
        len_eff   = stretch_len;
        is_retrig = (mode == MODE_RETRIG);
        is_edge   = (mode == MODE_EDGE);
        if (stretch_len == '0) begin
            len_eff = CNT_ONE;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             in_prev;
        logic             out_r;
        logic             busy_r;
        logic             missed_r;
        logic             trig;
        logic             miss_set;

        // Trigger qualification; EDGE mode additionally needs a low->high step.
        assign trig     = enable && in_pulse[i] && !(is_edge && in_prev);
        // A trigger is lost when holding off, or when running without RETRIG.
        assign miss_set = trig && ((state == ST_HOLDOFF) ||
                                   (state == ST_ACTIVE && !is_retrig));

        // Per-channel FSM: IDLE -> ACTIVE (Leff cycles) -> HOLDOFF -> IDLE.
        // The counter holds the cycles still to run and leaves its state on
        // the edge where it reads 1, so it never decrements through zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                in_prev  <= 1'b0;
                out_r    <= 1'b0;
                busy_r   <= 1'b0;
                missed_r <= 1'b0;
            end else begin
                // NOTE: sequential state is assigned with <= only, so every
                // right-hand side here sees the pre-edge value of every flop.
                in_prev <= in_pulse[i];

                if (miss_set) begin
                    missed_r <= 1'b1;
                end else if (clr_missed) begin
                    missed_r <= 1'b0;
                end

                case (state)
                    ST_IDLE: begin
                        if (trig) begin
                            state  <= ST_ACTIVE;
                            cnt    <= len_eff;
                            out_r  <= 1'b1;
                            busy_r <= 1'b1;
                        end
                    end

                    ST_ACTIVE: begin
                        if (trig && is_retrig) begin
                            cnt <= len_eff;
                        end else if (cnt <= CNT_ONE) begin
                            out_r <= 1'b0;
                            if (HOLDOFF > 0) begin
                                state <= ST_HOLDOFF;
                                cnt   <= HOLD_LOAD;
                            end else begin
                                state  <= ST_IDLE;
                                cnt    <= '0;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end

                    ST_HOLDOFF: begin
                        if (cnt <= CNT_ONE) begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            busy_r <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        out_r  <= 1'b0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end

        assign out_pulse[i] = out_r;
        assign busy[i]      = busy_r;
        assign missed[i]    = missed_r;
    end

endmodule
